frame_write_burst_ctrl: RTL
===========================

// Module: frame_write_burst_ctrl
// PURPOSE
//  Downstream of the rgb888 pixel-word source. Accepts 32-bit pixel words on the
//  write_user_buffer_* strobe interface and buffers them in an internal FIFO.
//  Drains the FIFO as fixed-length Avalon-MM burst writes into a frame buffer in DDR.
//  Advances the address linearly and wraps at end of frame.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of word 0 of the frame
//  FRAME_WORDS  1024           32-bit words per frame; must be a multiple of BURST_LEN
//  BURST_LEN    16             beats per burst, 1..FIFO_DEPTH
//  FIFO_DEPTH   256            FIFO depth in words, power of 2
//  BC_W         8              width of avm_burstcount; must hold BURST_LEN
// PORTS
//  clk                           in   1      single clock domain
//  rst                           in   1      synchronous reset, active high
//  write_user_buffer_input_data  in   32     pixel word
//  write_user_write_buffer       in   1      push strobe, one word per high cycle
//  write_user_buffer_full        out  1      FIFO full (count==FIFO_DEPTH)
//  avm_address                   out  32     burst start byte address
//  avm_burstcount                out  BC_W   always BURST_LEN while avm_write is high
//  avm_write                     out  1      write request
//  avm_writedata                 out  32     current beat data (FIFO head)
//  avm_waitrequest               in   1      slave stall
//  frame_done                    out  1      1-cycle pulse when last beat of frame is accepted
//  overflow                      out  1      sticky: a push was dropped
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - FIFO is emptied; count=0.
//   - All outputs are 0; avm_address=BASE_ADDR.
//   - State=IDLE; word_offset=0; overflow cleared.
//   - Reset mid-burst aborts the burst immediately. No beats are completed after reset.
//  FIFO:
//   - Show-ahead: avm_writedata = head word.
//   - A push is accepted when strobe=1 and count<FIFO_DEPTH.
//   - A push when count==FIFO_DEPTH is dropped and sets overflow, even if a pop occurs in the same cycle.
//   - Simultaneous push and pop: both take effect and count is unchanged.
//   - A pushed word is visible in count the next cycle.
//  Beat accept = avm_write & ~avm_waitrequest. Each accepted beat pops one word.
//  FSM:
//   - IDLE:
//     - When count>=BURST_LEN (registered count), next cycle enters BURST.
//     - On entry: avm_write=1, avm_address=BASE_ADDR+4*word_offset, avm_burstcount=BURST_LEN, beat_cnt=0.
//   - BURST:
//     - avm_address and avm_burstcount stay constant for the whole burst.
//     - avm_write stays high until the last beat is accepted.
//     - Each accepted beat increments beat_cnt.
//     - On acceptance of beat BURST_LEN-1: avm_write=0 next cycle.
//     - word_offset += BURST_LEN; if the result ==FRAME_WORDS, word_offset=0 and frame_done pulses for 1 cycle.
//     - Return to IDLE.
//   - Minimum of 1 IDLE cycle between bursts.
//   - Bursts are never started partially filled. Words are never reordered, duplicated or skipped.
//  Arithmetic:
//   - word_offset is $clog2(FRAME_WORDS) bits wide.
//   - The address is formed as BASE_ADDR + {word_offset,2'b00} and is 32-bit.
//  Latency: strobe on the BURST_LEN-th word at cycle N -> avm_write rises at N+2.
// TESTING
//  1. Hold rst 3 cycles:
//     - all outputs 0, avm_address=BASE_ADDR, write_user_buffer_full=0.
//  2. BURST_LEN=16, waitrequest=0, push words 0..15 on consecutive cycles:
//     - exactly 1 burst: addr=BASE_ADDR, burstcount=16, data 0..15 in order.
//     - avm_write rises 2 cycles after the 16th strobe.
//  3. As 2 with waitrequest pseudo-random (50%):
//     - data still 0..15, no duplicates or skips.
//     - address and burstcount stable while avm_write=1.
//  4. FRAME_WORDS=64, push 80 words:
//     - 5 bursts at BASE+0x000, +0x040, +0x080, +0x0C0, then BASE+0x000 again.
//     - frame_done pulses exactly once, the cycle after beat 63 is accepted.
//  5. FIFO_DEPTH=256, waitrequest=1, push 259 words:
//     - write_user_buffer_full=1 after the 256th push; 3 pushes dropped; overflow=1.
//     - Release waitrequest: 256 words drain in order; overflow stays 1 until rst.
//  6. Assert rst during beat 5 of a burst:
//     - avm_write=0 the next cycle, FIFO empty.
//     - After 16 new pushes, the next burst starts at BASE_ADDR with the new data.

Source files
------------

// File: rtl/frame_write_burst_ctrl.sv
// rtl/frame_write_burst_ctrl.sv - pixel-word FIFO drained as fixed-length Avalon-MM burst writes
module frame_write_burst_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          FRAME_WORDS = 1024,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 256,
  parameter int          BC_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     write_user_buffer_input_data,
  input  logic            write_user_write_buffer,
  output logic            write_user_buffer_full,
  output logic [31:0]     avm_address,
  output logic [BC_W-1:0] avm_burstcount,
  output logic            avm_write,
  output logic [31:0]     avm_writedata,
  input  logic            avm_waitrequest,
  output logic            frame_done,
  output logic            overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OFF_W  = $clog2(FRAME_WORDS);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_nxt;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [BEAT_W-1:0] beat_cnt;
  logic [OFF_W-1:0] word_offset;
  logic [OFF_W:0]   off_sum;
  logic [31:0]      addr_off;

  logic fifo_full, push_ok, beat_accept, last_beat, burst_start;

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok     = write_user_write_buffer && !fifo_full;
  assign beat_accept = avm_write && !avm_waitrequest;
  assign last_beat   = beat_accept && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign burst_start = (state == IDLE) && (state_nxt == BURST);
  assign off_sum     = {1'b0, word_offset} + (OFF_W + 1)'(BURST_LEN);
  assign addr_off    = {{(30 - OFF_W){1'b0}}, word_offset, 2'b00};

  assign write_user_buffer_full = fifo_full;

  // FIFO storage; pointers alone decide validity, so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= write_user_buffer_input_data;
  end

  // FIFO pointers, occupancy and sticky drop flag; a dropped push still flags overflow when a pop coincides
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (beat_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, beat_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (write_user_write_buffer && fifo_full) overflow <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start only on a full burst's worth of words, leave after the final beat
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count >= CNT_W'(BURST_LEN)) state_nxt = BURST;
      BURST:   if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs: request is the BURST state itself, data shown straight from the FIFO head
  always_comb begin
    avm_write      = (state == BURST);
    avm_burstcount = avm_write ? BC_W'(BURST_LEN) : '0;
    avm_writedata  = avm_write ? mem[rd_ptr] : '0;
  end

  // Burst address latch, beat counter and frame offset with wrap at end of frame
  always_ff @(posedge clk) begin
    if (rst) begin
      avm_address <= BASE_ADDR;
      beat_cnt    <= '0;
      word_offset <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (burst_start) begin
        avm_address <= BASE_ADDR + addr_off;
        beat_cnt    <= '0;
      end else if (beat_accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (last_beat) begin
        if (off_sum == (OFF_W + 1)'(FRAME_WORDS)) begin
          word_offset <= '0;
          frame_done  <= 1'b1;
        end else begin
          word_offset <= off_sum[OFF_W-1:0];
        end
      end
    end
  end

endmodule
